// File: rtl/f_fetch_queue.sv
// Instruction fetch queue: one outstanding imem request feeding a 2-entry {pc, instr} FIFO.
// A redirect flushes the FIFO and retargets fetch; a response already in flight is dropped.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request outstanding, response will be pushed
// DROP  | request outstanding, response will be discarded
module f_fetch_queue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_redirect,
    input  logic [31:0] in_npc,
    input  logic        in_stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ack,
    input  logic [31:0] in_imem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        busy;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] npc_word;

    assign busy     = (state != ST_IDLE);
    assign npc_word = in_npc & 32'hFFFF_FFFC;

    // Issue straight from IDLE so a request can follow an ack with no bubble.
    // Holding off during a redirect avoids requesting the soon-to-be-stale fetch_pc.
    assign issue = (state == ST_IDLE) && (count < 2'd2) && !in_redirect && !reset;
    assign push  = (state == ST_WAIT) && in_imem_ack && !in_redirect;
    assign pop   = out_valid && !in_stall && !in_redirect;

    assign out_imem_req  = busy || issue;
    assign out_imem_addr = busy ? req_addr : fetch_pc;

    assign out_valid = (count != 2'd0);
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_instr = fifo_instr[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (in_imem_ack)
                    state_nxt = ST_IDLE;
                else if (in_redirect)
                    state_nxt = ST_DROP;
            end
            ST_DROP: if (in_imem_ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= 32'h0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 32'h0;
                fifo_instr[i] <= 32'h0;
            end
        end else begin
            state <= state_nxt;
            if (issue)
                req_addr <= fetch_pc;
            if (in_redirect) begin
                fetch_pc <= npc_word;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (push) begin
                    fetch_pc           <= req_addr + 32'd4;
                    fifo_pc[wr_ptr]    <= req_addr;
                    fifo_instr[wr_ptr] <= in_imem_rdata;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                if (push && !pop)
                    count <= count + 2'd1;
                else if (pop && !push)
                    count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_f_fetch_queue.sv
// Bench for f_fetch_queue: directed scenarios plus a randomized run, all checked against
// a memory model and an expected-PC stream (sequential fetch, retargeted on redirect).
module tb_f_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_redirect;
    logic [31:0] in_npc;
    logic        in_stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_imem_req;
    logic [31:0] out_imem_addr;
    logic        in_imem_ack;
    logic [31:0] in_imem_rdata;

    int n_vec = 0;
    int n_err = 0;

    bit          mem_busy;
    logic [31:0] mem_addr;
    int          lat_left;
    int          lat_min;
    int          lat_max;
    logic [31:0] exp_pc;
    int          pops;

    always #5 clk = ~clk;

    f_fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .in_redirect  (in_redirect),
        .in_npc       (in_npc),
        .in_stall     (in_stall),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_imem_req (out_imem_req),
        .out_imem_addr(out_imem_addr),
        .in_imem_ack  (in_imem_ack),
        .in_imem_rdata(in_imem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Called at posedge+1; drives one cycle of inputs, checks, advances models, waits an edge.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] npc);
        in_stall      = stall;
        in_redirect   = redir;
        in_npc        = npc;
        in_imem_ack   = mem_busy && (lat_left == 0);
        in_imem_rdata = in_imem_ack ? word_of(mem_addr) : $urandom;
        #1;
        if (mem_busy) begin
            chk("req_held", {31'h0, out_imem_req}, 32'h1);
            chk("addr_held", out_imem_addr, mem_addr);
        end
        if (out_imem_req)
            chk("addr_align", {30'h0, out_imem_addr[1:0]}, 32'h0);
        if (out_valid && !stall && !redir) begin
            chk("pop_pc", out_pc, exp_pc);
            chk("pop_instr", out_instr, word_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir)
            exp_pc = npc & 32'hFFFF_FFFC;
        if (mem_busy) begin
            if (in_imem_ack) mem_busy = 0;
            else             lat_left--;
        end else if (out_imem_req) begin
            mem_busy = 1;
            mem_addr = out_imem_addr;
            lat_left = $urandom_range(lat_max, lat_min) - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        in_redirect   = 1'b0;
        in_stall      = 1'b0;
        in_imem_ack   = 1'b0;
        in_npc        = 32'h0;
        in_imem_rdata = 32'h0;
        mem_busy      = 0;
        exp_pc        = 32'h3000;
        pops          = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_req", {31'h0, out_imem_req}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        reset = 1'b0;
        #1;
        chk("first_req", {31'h0, out_imem_req}, 32'h1);
        chk("first_addr", out_imem_addr, 32'h3000);
    endtask

    initial begin
        // Scenario 1: 1-cycle memory, no stall
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (8) cycle(0, 0, 0);
        chk("s1_pops", {31'h0, pops >= 3}, 32'h1);

        // Scenario 2: hold stall until the queue saturates, then drain in order
        do_reset();
        repeat (6) cycle(1, 0, 0);
        chk("s2_req_off", {31'h0, out_imem_req}, 32'h0);
        chk("s2_valid", {31'h0, out_valid}, 32'h1);
        chk("s2_head", out_pc, 32'h3000);
        repeat (8) cycle(0, 0, 0);
        chk("s2_pops", {31'h0, pops >= 3}, 32'h1);

        // Scenario 3: 3-cycle memory, redirect while waiting
        lat_min = 3; lat_max = 3;
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 32'h4000);
        cycle(0, 0, 0);
        chk("s3_req", {31'h0, out_imem_req}, 32'h1);
        chk("s3_addr", out_imem_addr, 32'h4000);
        repeat (12) cycle(0, 0, 0);
        chk("s3_pops", {31'h0, pops >= 1}, 32'h1);

        // Scenario 4: redirect coincident with ack and a pop
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) cycle(1, 0, 0);
        chk("s4_ack_due", {31'h0, mem_busy && lat_left == 0 && out_valid}, 32'h1);
        cycle(0, 1, 32'h5002);
        chk("s4_empty", {31'h0, out_valid}, 32'h0);
        chk("s4_addr", out_imem_addr, 32'h5000);
        repeat (8) cycle(0, 0, 0);
        chk("s4_pops", {31'h0, pops >= 2}, 32'h1);

        // Scenario 5: full queue with traffic on both sides, 2-cycle memory
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (8) cycle(1, 0, 0);
        chk("s5_full_head", out_pc, 32'h3000);
        for (int i = 0; i < 20; i++) cycle(i[0], 0, 0);
        chk("s5_pops", {31'h0, pops >= 4}, 32'h1);

        // Scenario 6: reset mid-request with ack during and just after reset
        lat_min = 3; lat_max = 3;
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        reset         = 1'b1;
        in_imem_ack   = 1'b1;
        in_imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        in_stall = 1'b1;
        #1;
        chk("s6_valid", {31'h0, out_valid}, 32'h0);
        chk("s6_req", {31'h0, out_imem_req}, 32'h1);
        chk("s6_addr", out_imem_addr, 32'h3000);
        @(posedge clk);
        #1;
        chk("s6_no_push", {31'h0, out_valid}, 32'h0);
        mem_busy = 1; mem_addr = 32'h3000; lat_left = 0;
        exp_pc = 32'h3000; pops = 0;
        repeat (10) cycle(0, 0, 0);
        chk("s6_pops", {31'h0, pops >= 2}, 32'h1);

        // Randomized run
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] npc;
            npc = $urandom;
            cycle($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, npc);
        end
        chk("rand_progress", {31'h0, pops > 100}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
